// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares one FIFO write port between NUM_REQ
// valid/ready producers. Grants are held for bursts of up to MAX_BURST beats and stall
// (without counting) while the FIFO reports full. Beats pass combinationally to the FIFO.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          arb_en,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic                          grant_valid,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic [15:0]                   beat_count
);

    // Wide enough to hold MAX_BURST-1 even when MAX_BURST is 1
    localparam int unsigned BCW = $clog2(MAX_BURST + 1);
    localparam logic [BCW-1:0] BurstLast = BCW'(MAX_BURST - 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e              state_q;
    logic [ID_WIDTH-1:0] grant_id_q;
    logic [ID_WIDTH-1:0] last_id_q;
    logic [BCW-1:0]      burst_cnt_q;
    logic [15:0]         beat_count_q;

    logic                  sel_valid;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  beat;
    logic                  release_grant;
    logic [ID_WIDTH-1:0]   pick_base;
    logic [ID_WIDTH-1:0]   pick_id;
    logic                  pick_found;

    // Select the granted requester's valid and data
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_id_q == ID_WIDTH'(i)) begin
                sel_valid = req_valid[i];
                sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Beat qualification and release conditions
    always_comb begin
        beat          = (state_q == StGrant) && arb_en && sel_valid && !fifo_full;
        release_grant = (state_q == StGrant) &&
                        ((beat && (burst_cnt_q == BurstLast)) || !sel_valid || !arb_en);
    end

    // Zero-cycle beat path to the FIFO and the one-hot ready
    always_comb begin
        fifo_wr_en   = beat;
        fifo_wr_data = beat ? sel_data : '0;
        req_ready    = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            req_ready[i] = beat && (grant_id_q == ID_WIDTH'(i));
        end
    end

    // Round-robin search starting after the last grant; the current holder comes last
    always_comb begin
        int idx;
        idx        = 0;
        pick_base  = (state_q == StGrant) ? grant_id_q : last_id_q;
        pick_found = 1'b0;
        pick_id    = pick_base;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            idx = (int'(pick_base) + k) % int'(NUM_REQ);
            if (!pick_found && req_valid[ID_WIDTH'(idx)]) begin
                pick_found = 1'b1;
                pick_id    = ID_WIDTH'(idx);
            end
        end
    end

    // Grant FSM, burst length tracking and saturating beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            grant_id_q   <= '0;
            last_id_q    <= ID_WIDTH'(NUM_REQ - 1);
            burst_cnt_q  <= '0;
            beat_count_q <= '0;
        end else begin
            if (beat && (beat_count_q != 16'hFFFF)) begin
                beat_count_q <= beat_count_q + 16'd1;
            end
            case (state_q)
                StIdle: begin
                    if (arb_en && pick_found) begin
                        state_q     <= StGrant;
                        grant_id_q  <= pick_id;
                        last_id_q   <= pick_id;
                        burst_cnt_q <= '0;
                    end
                end
                StGrant: begin
                    if (beat) begin
                        burst_cnt_q <= burst_cnt_q + BCW'(1);
                    end
                    if (release_grant) begin
                        burst_cnt_q <= '0;
                        // Re-grant on the same edge so back-to-back bursts have no bubble
                        if (arb_en && pick_found) begin
                            grant_id_q <= pick_id;
                            last_id_q  <= pick_id;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign grant_valid = (state_q == StGrant);
    assign grant_id    = grant_id_q;
    assign beat_count  = beat_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: table-driven vectors for the basic single-requester case,
// hand-written sequences for bursts, stalls, arb_en drop and mid-burst reset, with a
// scoreboard queue of expected {grant id, data} writes.
module tb_fifo_wr_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              arb_en;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_wr_data;
    logic              grant_valid;
    logic [1:0]        grant_id;
    logic [15:0]       beat_count;

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (4),
        .ID_WIDTH   (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arb_en       (arb_en),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .beat_count   (beat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic        en;
        logic [3:0]  valid;
        logic        full;
        logic        wr_en;
        logic        gv;
        logic [1:0]  gid;
        logic [3:0]  rdy;
        logic [15:0] cnt;
    } vec_t;

    exp_t        sbq[$];
    vec_t        vecs[6];
    int unsigned seq[NR];
    int unsigned exp_seq[NR];
    logic [3:0]  acc;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] cnt0;

    // Beat payload: requester id in the top bits, per-requester sequence number below
    function automatic logic [7:0] mk(int id, int unsigned s);
        return {3'(id), 5'(s)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < int'(NR); i++) req_data[i*DW +: DW] = mk(i, seq[i]);
    endtask

    task automatic push(input int id, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.id   = 2'(id);
            e.data = mk(id, exp_seq[id]);
            exp_seq[id]++;
            sbq.push_back(e);
        end
    endtask

    // Sample on the falling edge; every write is matched against the scoreboard
    task automatic sample();
        exp_t e;
        @(negedge clk);
        if (fifo_wr_en) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected_write: got id %0d data 0x%0h, expected no write",
                         grant_id, fifo_wr_data);
            end else begin
                e = sbq.pop_front();
                check("sb_data", 32'(fifo_wr_data), 32'(e.data));
                check("sb_id", 32'(grant_id), 32'(e.id));
                check("sb_ready", 32'(req_ready), 32'(4'b0001 << e.id));
            end
        end
        acc = req_ready;
    endtask

    // Advance past the rising edge; producers move to their next beat once accepted
    task automatic advance();
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(NR); i++) if (acc[i]) seq[i]++;
        acc = '0;
        drive_data();
    endtask

    task automatic cycle(input int n);
        for (int k = 0; k < n; k++) begin
            sample();
            advance();
        end
    endtask

    task automatic check_empty(input string name);
        check(name, 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    // Assert reset with requests pending; outputs must be quiet throughout
    task automatic do_reset();
        arb_en    = 1'b1;
        req_valid = '1;
        fifo_full = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rst_grant_valid", 32'(grant_valid), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_wr_data", 32'(fifo_wr_data), 32'd0);
        check("rst_beat_count", 32'(beat_count), 32'd0);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n     = 1'b1;
        acc       = '0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 16'd0};
        vecs[1] = '{1'b1, 4'b0001, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 16'd0};
        vecs[2] = '{1'b1, 4'b0001, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 16'd1};
        vecs[3] = '{1'b1, 4'b0001, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 16'd2};
        vecs[4] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 16'd3};
        vecs[5] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 16'd3};

        for (int i = 0; i < int'(NR); i++) begin
            seq[i]     = 0;
            exp_seq[i] = 0;
        end
        acc = '0;
        drive_data();
        do_reset();

        // Requester 0 alone for 3 beats, then valid drops
        push(0, 3);
        for (int i = 0; i < 6; i++) begin
            arb_en    = vecs[i].en;
            req_valid = vecs[i].valid;
            fifo_full = vecs[i].full;
            sample();
            check($sformatf("vec%0d_wr_en", i), 32'(fifo_wr_en), 32'(vecs[i].wr_en));
            check($sformatf("vec%0d_grant_valid", i), 32'(grant_valid), 32'(vecs[i].gv));
            check($sformatf("vec%0d_grant_id", i), 32'(grant_id), 32'(vecs[i].gid));
            check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].rdy));
            check($sformatf("vec%0d_beat_count", i), 32'(beat_count), 32'(vecs[i].cnt));
            if (!vecs[i].wr_en) check($sformatf("vec%0d_wr_data", i), 32'(fifo_wr_data), 32'd0);
            advance();
        end
        check_empty("t1_sb_empty");

        // All four valid: grant order 0,1,2,3,0 in bursts of 4 with no gaps
        do_reset();
        arb_en    = 1'b1;
        req_valid = 4'b1111;
        push(0, 4); push(1, 4); push(2, 4); push(3, 4); push(0, 4);
        sample();
        check("t2_arb_latency_gv", 32'(grant_valid), 32'd0);
        advance();
        check("t2_first_grant", 32'(grant_id), 32'd0);
        for (int k = 0; k < 16; k++) begin
            sample();
            check("t2_wr_en", 32'(fifo_wr_en), 32'd1);
            advance();
        end
        check("t2_beat_count16", 32'(beat_count), 32'd16);
        cycle(4);
        check_empty("t2_sb_empty");
        req_valid = '0;
        cycle(2);
        check("t2_idle", 32'(grant_valid), 32'd0);

        // Requester 2 alone: back-to-back bursts with no gap
        req_valid = 4'b0100;
        push(2, 12);
        cycle(1);
        for (int k = 0; k < 12; k++) begin
            sample();
            check("t3_wr_en", 32'(fifo_wr_en), 32'd1);
            advance();
        end
        check_empty("t3_sb_empty");
        req_valid = '0;
        cycle(2);

        // Requesters 1 and 2; FIFO full for 3 cycles after beat 2 of requester 1's burst
        req_valid = 4'b0110;
        push(1, 4); push(2, 4);
        cycle(1);
        check("t4_grant1", 32'(grant_id), 32'd1);
        cycle(2);
        cnt0      = beat_count;
        fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sample();
            check("t4_stall_wr_en", 32'(fifo_wr_en), 32'd0);
            check("t4_stall_ready", 32'(req_ready), 32'd0);
            check("t4_stall_wr_data", 32'(fifo_wr_data), 32'd0);
            check("t4_stall_gv", 32'(grant_valid), 32'd1);
            check("t4_stall_gid", 32'(grant_id), 32'd1);
            check("t4_stall_count", 32'(beat_count), 32'(cnt0));
            advance();
        end
        fifo_full = 1'b0;
        cycle(2);
        check("t4_regrant2", 32'(grant_id), 32'd2);
        cycle(4);
        check_empty("t4_sb_empty");
        req_valid = '0;
        cycle(2);

        // arb_en dropped on the first beat of requester 1; resume goes to 3
        do_reset();
        arb_en    = 1'b1;
        req_valid = 4'b1010;
        cycle(1);
        check("t5_grant1", 32'(grant_id), 32'd1);
        arb_en = 1'b0;
        sample();
        check("t5_noen_wr_en", 32'(fifo_wr_en), 32'd0);
        check("t5_noen_ready", 32'(req_ready), 32'd0);
        advance();
        check("t5_idle_gv", 32'(grant_valid), 32'd0);
        check("t5_idle_gid", 32'(grant_id), 32'd1);
        arb_en = 1'b1;
        sample();
        check("t5_idle_wr_en", 32'(fifo_wr_en), 32'd0);
        advance();
        check("t5_grant3", 32'(grant_id), 32'd3);
        check("t5_grant3_gv", 32'(grant_valid), 32'd1);
        push(3, 2);
        cycle(2);
        req_valid = '0;
        cycle(2);
        check_empty("t5_sb_empty");

        // Asynchronous reset in the middle of a burst
        req_valid = 4'b0001;
        push(0, 2);
        cycle(3);
        check_empty("t6_sb_empty_pre");
        rst_n = 1'b0;
        #1;
        check("t6_rst_gv", 32'(grant_valid), 32'd0);
        check("t6_rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("t6_rst_ready", 32'(req_ready), 32'd0);
        check("t6_rst_count", 32'(beat_count), 32'd0);
        check("t6_rst_gid", 32'(grant_id), 32'd0);
        req_valid = 4'b1111;
        sample();
        advance();
        rst_n = 1'b1;
        sample();
        check("t6_post_gv", 32'(grant_valid), 32'd0);
        advance();
        check("t6_post_grant0", 32'(grant_id), 32'd0);
        check("t6_post_gv1", 32'(grant_valid), 32'd1);
        push(0, 1);
        sample();
        advance();
        req_valid = '0;
        cycle(2);
        check_empty("t6_sb_empty");
        check("t6_count1", 32'(beat_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
